dmem_responder: RTL and testbench

- Data-memory slave that answers the processor core's data-memory port: the separate load and store byte addresses, the read and write enables, the write data, and the returned read data.
- Holds a word-addressed 64-bit array.
- Serves loads through a fixed-latency read pipeline and commits stores in one cycle.
- Flags misaligned or out-of-range accesses.
- Sits beside the core in the top-level bench and in synthesis wrappers, replacing the behavioural memory model.

---
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's data port: word-addressed 64-bit array,
// fixed-latency load pipeline, single-cycle stores, sticky bad-access capture.
module dmem_responder #(
  parameter int DEPTH        = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] dmem_addressLoad,
  input  logic [63:0] dmem_addressStore,
  input  logic        dmem_readEn,
  input  logic        dmem_writeEn,
  input  logic [63:0] dmem_WriteData,
  output logic [63:0] dmem_readData,
  output logic        read_valid_o,
  output logic        access_err_o,
  output logic [63:0] err_addr_o
);

  localparam int W = $clog2(DEPTH);

  // Misaligned, or beyond the last word of the array.
  function automatic logic addr_bad(input logic [63:0] a);
    addr_bad = (a[2:0] != 3'b000) || ((a >> (W + 3)) != 64'd0);
  endfunction

  logic [63:0]             mem_r [DEPTH];
  logic [READ_LATENCY-1:0] vld_r;
  logic [63:0]             dat_r [READ_LATENCY];
  logic                    err_r;
  logic [63:0]             err_addr_r;

  logic                    ld_bad_s;
  logic                    st_bad_s;
  logic                    st_ok_s;
  logic [W-1:0]            ld_idx_s;
  logic [W-1:0]            st_idx_s;
  logic [63:0]             ld_data_s;

  assign ld_bad_s = addr_bad(dmem_addressLoad);
  assign st_bad_s = addr_bad(dmem_addressStore);
  assign ld_idx_s = dmem_addressLoad[W+2:3];
  assign st_idx_s = dmem_addressStore[W+2:3];
  assign st_ok_s  = dmem_writeEn && !st_bad_s;

  // Issue-stage data: bad loads read 0, a same-cycle store to the same word forwards.
  always_comb begin
    ld_data_s = 64'd0;
    if (ld_bad_s) begin
      ld_data_s = 64'd0;
    end else if (st_ok_s && (st_idx_s == ld_idx_s)) begin
      ld_data_s = dmem_WriteData;
    end else begin
      ld_data_s = mem_r[ld_idx_s];
    end
  end

  // Storage array; cleared on reset, written by good stores only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (st_ok_s) begin
      mem_r[st_idx_s] <= dmem_WriteData;
    end
  end

  // Load pipeline; the final stage holds its data while no result arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_r[i] <= 64'd0;
      end
    end else begin
      vld_r[0] <= dmem_readEn;
      if (READ_LATENCY == 1) begin
        if (dmem_readEn) begin
          dat_r[0] <= ld_data_s;
        end
      end else begin
        dat_r[0] <= dmem_readEn ? ld_data_s : 64'd0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (i == READ_LATENCY - 1) begin
          if (vld_r[i-1]) begin
            dat_r[i] <= dat_r[i-1];
          end
        end else begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  // First bad access wins and sticks; a bad store outranks a bad load in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r      <= 1'b0;
      err_addr_r <= 64'd0;
    end else if (!err_r) begin
      if (dmem_writeEn && st_bad_s) begin
        err_r      <= 1'b1;
        err_addr_r <= dmem_addressStore;
      end else if (dmem_readEn && ld_bad_s) begin
        err_r      <= 1'b1;
        err_addr_r <= dmem_addressLoad;
      end
    end
  end

  assign dmem_readData = dat_r[READ_LATENCY-1];
  assign read_valid_o  = vld_r[READ_LATENCY-1];
  assign access_err_o  = err_r;
  assign err_addr_o    = err_addr_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 2, 3) share one stimulus
// stream; a behavioural model pushes expected load results into per-instance queues.
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int W     = $clog2(DEPTH);
  localparam int NI    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr_ld;
  logic [63:0] addr_st;
  logic        ren;
  logic        wen;
  logic [63:0] wdata;

  logic [63:0] rd_data  [NI];
  logic        rd_valid [NI];
  logic        err_o    [NI];
  logic [63:0] err_addr [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(.DEPTH(DEPTH), .READ_LATENCY(g + 1)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_addressLoad (addr_ld),
        .dmem_addressStore(addr_st),
        .dmem_readEn      (ren),
        .dmem_writeEn     (wen),
        .dmem_WriteData   (wdata),
        .dmem_readData    (rd_data[g]),
        .read_valid_o     (rd_valid[g]),
        .access_err_o     (err_o[g]),
        .err_addr_o       (err_addr[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          due;
  } ent_t;

  ent_t        sb [NI][$];
  logic [63:0] mdl_mem [DEPTH];
  logic [63:0] last_d [NI];
  logic        mdl_err;
  logic [63:0] mdl_err_addr;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  function automatic bit is_bad(input logic [63:0] a);
    return (a[2:0] != 3'b000) || ((a >> (W + 3)) != 64'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: evaluates each edge from the inputs, schedules load results.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 64'd0;
      for (int k = 0; k < NI; k++) begin
        sb[k].delete();
        last_d[k] = 64'd0;
      end
      mdl_err      = 1'b0;
      mdl_err_addr = 64'd0;
    end else begin
      logic [63:0] ld;
      bit          st_ok;
      cyc++;
      st_ok = wen && !is_bad(addr_st);
      if (is_bad(addr_ld)) ld = 64'd0;
      else if (st_ok && (addr_st[W+2:3] == addr_ld[W+2:3])) ld = wdata;
      else ld = mdl_mem[addr_ld[W+2:3]];
      if (st_ok) mdl_mem[addr_st[W+2:3]] = wdata;
      if (!mdl_err) begin
        if (wen && is_bad(addr_st)) begin
          mdl_err = 1'b1;
          mdl_err_addr = addr_st;
        end else if (ren && is_bad(addr_ld)) begin
          mdl_err = 1'b1;
          mdl_err_addr = addr_ld;
        end
      end
      if (ren) begin
        for (int k = 0; k < NI; k++) begin
          ent_t e;
          e.d   = ld;
          e.due = cyc + k;
          sb[k].push_back(e);
        end
      end
    end
  end

  // Scoreboard: pop on the due cycle, otherwise require idle with held data.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
        ent_t e;
        e = sb[k].pop_front();
        chk($sformatf("L%0d_valid", k + 1), {63'd0, rd_valid[k]}, 64'd1);
        chk($sformatf("L%0d_data", k + 1), rd_data[k], e.d);
        last_d[k] = e.d;
      end else begin
        chk($sformatf("L%0d_idle_valid", k + 1), {63'd0, rd_valid[k]}, 64'd0);
        chk($sformatf("L%0d_hold_data", k + 1), rd_data[k], last_d[k]);
      end
      chk($sformatf("L%0d_err", k + 1), {63'd0, err_o[k]}, {63'd0, mdl_err});
      chk($sformatf("L%0d_err_addr", k + 1), err_addr[k], mdl_err_addr);
    end
  end

  task automatic drive(input bit re, input logic [63:0] la, input bit we,
                       input logic [63:0] sa, input logic [63:0] wd);
    @(posedge clk);
    #2;
    ren     = re;
    addr_ld = la;
    wen     = we;
    addr_st = sa;
    wdata   = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    ren   = 1'b0;
    wen   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    ren = 1'b0; wen = 1'b0; addr_ld = 64'd0; addr_st = 64'd0; wdata = 64'd0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    idle(2);

    // store then load
    drive(1'b0, 64'd0, 1'b1, 64'h10, 64'h1122334455667788);
    drive(1'b1, 64'h10, 1'b0, 64'd0, 64'd0);
    idle(4);

    // same-cycle forwarding, then different-index store with load
    drive(1'b1, 64'h18, 1'b1, 64'h18, 64'hAAAA);
    drive(1'b1, 64'h20, 1'b1, 64'h18, 64'hBBBB);
    drive(1'b1, 64'h18, 1'b0, 64'd0, 64'd0);
    idle(4);

    // back-to-back loads; later store to 0x8 must not alter in-flight load
    drive(1'b0, 64'd0, 1'b1, 64'h0,  64'd1);
    drive(1'b0, 64'd0, 1'b1, 64'h8,  64'd2);
    drive(1'b0, 64'd0, 1'b1, 64'h10, 64'd3);
    drive(1'b0, 64'd0, 1'b1, 64'h18, 64'd4);
    drive(1'b1, 64'h0,  1'b0, 64'd0, 64'd0);
    drive(1'b1, 64'h8,  1'b0, 64'd0, 64'd0);
    drive(1'b1, 64'h10, 1'b1, 64'h8, 64'd9);
    drive(1'b1, 64'h18, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 64'h8,  1'b0, 64'd0, 64'd0);
    idle(4);

    // idle gap holds last data
    drive(1'b0, 64'd0, 1'b1, 64'h28, 64'h77);
    drive(1'b1, 64'h28, 1'b0, 64'd0, 64'd0);
    idle(6);

    // error capture: misaligned load, out-of-range store, word 0 untouched
    drive(1'b1, 64'h0C, 1'b0, 64'd0, 64'd0);
    drive(1'b0, 64'd0, 1'b1, 64'(DEPTH * 8), 64'h55);
    drive(1'b1, 64'h0, 1'b0, 64'd0, 64'd0);
    idle(4);

    // simultaneous bad load and bad store after a fresh reset
    pulse_reset();
    drive(1'b1, 64'h3, 1'b1, 64'h1000_0000_0000_0008, 64'h1);
    idle(4);

    // reset while a load is in flight
    pulse_reset();
    drive(1'b0, 64'd0, 1'b1, 64'h30, 64'h5A);
    drive(1'b1, 64'h30, 1'b0, 64'd0, 64'd0);
    pulse_reset();
    idle(3);
    drive(1'b1, 64'h30, 1'b0, 64'd0, 64'd0);
    idle(4);

    // mixed random traffic over a few words with occasional bad addresses
    for (int i = 0; i < 40; i++) begin
      logic [63:0] la;
      logic [63:0] sa;
      la = 64'($urandom_range(0, 7)) << 3;
      sa = 64'($urandom_range(0, 7)) << 3;
      if ($urandom_range(0, 15) == 0) la = la | 64'h4;
      if ($urandom_range(0, 15) == 0) sa = sa | 64'h8000;
      drive(1'($urandom_range(0, 1)), la, 1'($urandom_range(0, 1)), sa,
            {32'($urandom), 32'($urandom)});
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
